// File: rtl/axi_defs.sv
// Shared AXI constants, FSM state encoding and width helpers
// for the DDR read-back path.
package axi_defs;

   localparam logic [2:0] ASIZE_32B   = 3'b101;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic       ATYPE_READ  = 1'b0;
   localparam logic       ATYPE_WRITE = 1'b1;

   localparam int DEF_WORD_WIDTH = 256;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int WORD_BYTES     = DEF_WORD_WIDTH / DEF_DATA_WIDTH;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      UNPACK,
      FIN
   } state_t;

   function automatic int word_bytes(input int ww, input int dw);
      return ww / dw;
   endfunction

endpackage

// File: rtl/word_unpacker.sv
// Holds one AXI read word and streams it out LSB byte first
// on a valid/ready interface.
module word_unpacker
   import axi_defs::*;
#(
   parameter int WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [WORD_WIDTH-1:0] word_in,
   input  logic                  byte_ready,
   output logic [DATA_WIDTH-1:0] byte_data,
   output logic                  byte_valid,
   output logic                  last_byte,
   output logic                  word_done
);

   localparam int NB = word_bytes(WORD_WIDTH, DATA_WIDTH);
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IW-1:0] LAST = IW'(NB - 1);

   logic [WORD_WIDTH-1:0] word_reg;
   logic [IW-1:0]         byte_idx;
   logic [IW-1:0]         next_idx;

   assign next_idx  = byte_idx + IW'(1);
   assign last_byte = (byte_idx == LAST);
   assign word_done = byte_valid && byte_ready && last_byte;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_reg   <= '0;
         byte_idx   <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
      end else if (load) begin
         word_reg   <= word_in;
         byte_idx   <= '0;
         byte_valid <= 1'b1;
         byte_data  <= word_in[DATA_WIDTH-1:0];
      end else if (byte_valid && byte_ready) begin
         if (last_byte) begin
            byte_valid <= 1'b0;
         end else begin
            byte_idx  <= next_idx;
            byte_data <= word_reg[DATA_WIDTH*next_idx +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/axi_read_unpacker.sv
// Reads num_words single-beat AXI words from ADDR_BASE and
// replays them as a byte stream for the UART transmit side.
module axi_read_unpacker
   import axi_defs::*;
#(
   parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
   parameter int          WORD_WIDTH = 256,
   parameter int          DATA_WIDTH = 8,
   parameter int          CNT_WIDTH  = 16
) (
   input  logic                  axi_clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  num_words,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_err,
   output logic [7:0]            aid,
   output logic [31:0]           aaddr,
   output logic [7:0]            alen,
   output logic [2:0]            asize,
   output logic [1:0]            aburst,
   output logic [1:0]            alock,
   output logic                  avalid,
   input  logic                  aready,
   output logic                  atype,
   input  logic [7:0]            rid,
   input  logic [WORD_WIDTH-1:0] rdata,
   input  logic                  rlast,
   input  logic                  rvalid,
   output logic                  rready,
   input  logic [1:0]            rresp,
   output logic [DATA_WIDTH-1:0] byte_data,
   output logic                  byte_valid,
   input  logic                  byte_ready
);

   localparam logic [31:0] STRIDE = 32'(WORD_WIDTH / 8);

   state_t               state;
   state_t               state_n;
   logic [CNT_WIDTH-1:0] words_left;
   logic                 load;
   logic                 last_byte;
   logic                 word_done;
   logic                 run_go;
   logic                 zero_go;
   logic                 unused_rid;

   assign aid        = 8'h00;
   assign alen       = 8'h00;
   assign asize      = ASIZE_32B;
   assign aburst     = BURST_INCR;
   assign alock      = 2'b00;
   assign atype      = ATYPE_READ;
   assign unused_rid = ^{rid, last_byte};

   assign avalid = (state == ADDR);
   assign rready = (state == DATA);
   assign busy   = (state == ADDR) || (state == DATA) ||
                   (state == UNPACK);
   assign load   = rready && rvalid;

   assign run_go  = (state == IDLE) && start && (num_words != '0);
   assign zero_go = (state == IDLE) && start && (num_words == '0);

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (run_go) state_n = ADDR;
         ADDR:    if (aready) state_n = DATA;
         DATA:    if (rvalid) state_n = UNPACK;
         UNPACK: begin
            if (word_done)
               state_n = (words_left == CNT_WIDTH'(1)) ? FIN : ADDR;
         end
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge axi_clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         done       <= 1'b0;
         rd_err     <= 1'b0;
         words_left <= '0;
         aaddr      <= ADDR_BASE;
      end else begin
         state <= state_n;
         done  <= (state_n == FIN) || zero_go;
         if (run_go) begin
            words_left <= num_words;
            aaddr      <= ADDR_BASE;
            rd_err     <= 1'b0;
         end
         // A bad beat is flagged but its data still goes out.
         if (load && ((rresp != RESP_OKAY) || !rlast))
            rd_err <= 1'b1;
         if ((state == UNPACK) && word_done) begin
            words_left <= words_left - CNT_WIDTH'(1);
            if (words_left != CNT_WIDTH'(1))
               aaddr <= aaddr + STRIDE;
         end
      end
   end

   word_unpacker #(
      .WORD_WIDTH (WORD_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_unpack (
      .clk        (axi_clk),
      .rst_n      (rstn),
      .load       (load),
      .word_in    (rdata),
      .byte_ready (byte_ready),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .last_byte  (last_byte),
      .word_done  (word_done)
   );

endmodule

// File: doc/axi_read_unpacker.md
Name: axi_read_unpacker

Overview:
- Read-back stage downstream of the DDR write path (uart rx -> sync_fifo -> packer -> async_top -> axi).
- Issues single-beat AXI reads over the shared address channel from a base address and captures each 256-bit rdata word.
- Unpacks each word into bytes, LSB byte first, on a valid/ready byte stream that feeds the UART transmit side.
- Lets the team check the DDR contents end-to-end over UART.

Parameters:
- ADDR_BASE, 32'h0000_0000, DDR byte address of the first word read.
- WORD_WIDTH, 256, AXI data width in bits; must be a multiple of DATA_WIDTH.
- DATA_WIDTH, 8, output byte width.
- CNT_WIDTH, 16, width of the word-count input and counters.

Ports:
- axi_clk  in  1  single clock for all logic.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a read-back; ignored while busy.
- num_words  in  CNT_WIDTH  number of 256-bit words to read; sampled when start is accepted.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at the end of a run.
- rd_err  out  1  sticky; set when any beat has rresp!=0 or rlast==0; cleared by an accepted start.
- aid  out  8  constant 8'h00.
- aaddr  out  32  read address.
- alen  out  8  constant 0 (single beat).
- asize  out  3  constant 3'b101 (32 bytes).
- aburst  out  2  constant 2'b01 (INCR).
- alock  out  2  constant 2'b00.
- avalid  out  1  address valid.
- aready  in  1  slave accepts address.
- atype  out  1  constant 0 (read).
- rid  in  8  read id; not checked.
- rdata  in  WORD_WIDTH  read data.
- rlast  in  1  last beat; expected 1 on every beat.
- rvalid  in  1  read data valid.
- rready  out  1  master ready for read data.
- rresp  in  2  read response.
- byte_data  out  DATA_WIDTH  unpacked byte.
- byte_valid  out  1  byte_data valid.
- byte_ready  in  1  consumer (UART tx) accepts byte.

Behaviour:
- Reset (rstn low, async) clears: state=IDLE, avalid, rready, byte_valid, busy, done, rd_err all 0; aaddr=ADDR_BASE; byte_data=0.
- Reset mid-run aborts with no output pulse. An outstanding AXI transaction is abandoned; the system resets DDR/AXI together.
- FSM states: IDLE, ADDR, DATA, UNPACK, FIN.
- IDLE:
  - start && num_words!=0: latch words_left=num_words, aaddr=ADDR_BASE, clear rd_err, busy=1, go to ADDR next cycle.
  - start && num_words==0: done pulses next cycle; busy stays 0; state stays IDLE.
- ADDR:
  - avalid=1, aaddr held stable until handshake.
  - On avalid&&aready: avalid=0 next cycle, go to DATA.
- DATA:
  - rready=1.
  - On rvalid&&rready: register rdata into word_reg; set rd_err if rresp!=2'b00 or rlast==0; rready=0 next cycle; byte_idx=0; go to UNPACK.
  - rdata is still captured on error; the run continues.
- UNPACK:
  - byte_valid=1; byte_data=word_reg[DATA_WIDTH*byte_idx +: DATA_WIDTH] (registered output).
  - byte_data/byte_valid hold stable while byte_ready=0.
  - On byte_valid&&byte_ready:
    - byte_idx != last (31): byte_idx++, next byte presented the following cycle.
    - byte_idx == last: byte_valid=0, words_left--.
      - words_left becomes 0: go to FIN.
      - Otherwise: aaddr += WORD_WIDTH/8 (32, wraps modulo 2^32), go to ADDR.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- Throughput: max one byte per cycle.
- Per-word overhead, assuming aready and rvalid are immediate: 2 cycles (ADDR, DATA) before the first byte is valid.
- Simultaneous events:
  - start while busy: ignored.
  - start in the FIN cycle: ignored; accepted from IDLE one cycle later.
- Only one AXI read is outstanding at any time; a new address is never issued before all bytes of the current word are consumed.

Decomposition:
- Shared package (axi_defs):
  - AXI constants: ASIZE_32B=3'b101, BURST_INCR=2'b01, RESP_OKAY=2'b00, ATYPE_READ=0, ATYPE_WRITE=1.
  - FSM state enum.
  - WORD_BYTES = WORD_WIDTH/DATA_WIDTH.
- One natural sub-module: word_unpacker (word_reg load, byte_idx counter, valid/ready byte output, last_byte flag). The top keeps the FSM and AXI channels.

Test Plan:
- Setup: num_words=1, aready/rvalid immediate, rdata bytes 0x00..0x1F (byte k = k), byte_ready=1.
  - aaddr=0x0, alen=0, asize=5, atype=0.
  - 32 bytes 0x00..0x1F on consecutive cycles.
  - done pulses once; rd_err=0.
- Setup: num_words=3.
  - Three address handshakes at aaddr 0x00, 0x20, 0x40.
  - 96 bytes in order; done after the last byte.
- Setup: byte_ready toggled 1/0 randomly, aready delayed 5 cycles.
  - byte_data held stable while stalled; no byte lost or duplicated.
  - aaddr/avalid stable until aready.
- Setup: rresp=2'b10 on word 2 of 3.
  - rd_err=1 and stays 1; all 96 bytes still delivered; done pulses.
  - Next start clears rd_err.
- Setup: start with num_words=0 -> done pulse next cycle, busy=0, no avalid. Second case: start asserted while busy -> ignored.
- Setup: rstn asserted low mid-UNPACK (byte 10).
  - All outputs 0 immediately, state IDLE.
  - Fresh start with num_words=1 behaves as in scenario 1.
